mul_sched: RTL and testbench
============================

# mul_sched

Sequencing and arbitration controller for the 3-bit sign-magnitude multiplier `mul`. It shares one `mul` instance between two requester ports and latches operands under a valid/ready handshake. It holds each operation for a parameterised number of compute cycles, then returns the registered 5-bit sign-magnitude product on the originating requester's response port. It sits between the calculator front-end and the multiply datapath.

## Interface
Parameters:
- `MUL_LAT`, default 1: number of CALC cycles before the product is captured. Legal range 1..7.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  requester offers an operand pair.
- `req0_ready` / `req1_ready`  out  1  operands accepted this cycle. Combinational from state and grant.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  3 each  sign-magnitude operands. Bit [2] is the sign; bits [1:0] are the magnitude.
- `rsp0_valid` / `rsp1_valid`  out  1  product available for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes the product.
- `rsp0_product` / `rsp1_product`  out  5  sign-magnitude product. Bit [4] is the sign; bits [3:0] are the magnitude.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE:**
  - Grant goes to the requester with valid set.
  - If both are valid, the round-robin pointer `rr` decides: `rr=0` favours requester 0.
  - Only the granted port's `reqN_ready` is high. The other port's ready is 0.
  - On the handshake edge: latch a, b and the owner id; load the cycle counter with `MUL_LAT-1`; go to CALC.
- **CALC:**
  - The latched operands drive `mul`.
  - The counter decrements each cycle.
  - In the cycle the counter reads 0: register `mul.product` into the result register and go to RESP.
- **RESP:**
  - Only the owner's `rspN_valid` is high. Both `rspN_product` ports show the result register, but only the owner's valid qualifies it.
  - Valid and product stay stable until `rspN_ready` is sampled high.
  - On that edge: clear valid, set `rr` to the other requester, return to IDLE.
- Arithmetic is owned by `mul` and is not recomputed here:
  - Magnitude is the unsigned 2×2 product a[1:0]·b[1:0], range 0..9.
  - Sign is a[2]^b[2], forced to 0 when either magnitude is 0. Negative-zero input (100) therefore yields 00000.
- No requests are accepted while in CALC or RESP. A requester holds `reqN_valid` and its operands until it sees ready.
- A requester that drops valid before ready is not recorded; no partial state is kept.

## Timing
- Reset values (the `rst_n` low edge forces all of these):
  - State IDLE; `rr`=0; counter 0; result 00000.
  - All `reqN_ready`=0 while `rst_n` is low.
  - All `rspN_valid`=0; `busy`=0.
- Reset mid-operation, in CALC or RESP: the transaction is discarded and no response is issued. Ready may assert in the first cycle after `rst_n` rises.
- Latency:
  - Request handshake at edge N.
  - `rspN_valid` is high from cycle N+`MUL_LAT`+1 (N+2 at default).
- Minimum issue interval is `MUL_LAT`+2 cycles when `rsp_ready` is tied high.
- Back-pressure: `rspN_ready` held low keeps the FSM in RESP indefinitely. No new grant is made and `busy` stays 1.
- Fairness: with both requesters permanently valid, grants strictly alternate 0,1,0,1…
- In IDLE, a valid from the non-favoured port alone is granted immediately; `rr` does not block it.

## Structure
- Shared package `calc_pkg`:
  - `OP_W=3`, `RES_W=5`.
  - State enum {IDLE, CALC, RESP}.
  - Sign-magnitude bit-position constants.
- One sub-module, the existing `mul`, is instantiated once.
- The arbiter, FSM and counter stay inline; no further hierarchy.

## Test plan
- Single request, default latency: req0 a=011 (+3), b=110 (−2) handshaken at edge N → `rsp0_valid` at N+2, `rsp0_product`=10110 (−6); `rsp1_valid` stays 0.
- Simultaneous requests:
  - Setup: after reset, req0 (111×111) and req1 (010×001) are both valid.
  - Expected: req0 is served first with product 01001 (+9). req1 is granted next, product 00010.
  - Both handshakes complete, confirming `rr` alternation.
- Back-pressure: hold `rsp1_ready`=0 for 5 cycles with req0 valid → product stable; `req0_ready`=0 throughout and `busy`=1; req0 is granted in the cycle after RESP exits.
- Zero/negative-zero: 100×011 and 101×000 → product 00000 in both cases (sign cleared).
- Reset mid-CALC with `MUL_LAT`=4: assert `rst_n`=0 at the second CALC cycle → next cycle all outputs are at reset values and no `rsp_valid` ever appears for that transaction.
- Exhaustive sweep: all 64 operand pairs alternately on ports 0/1 with random ready stalls → every product matches the sign-magnitude reference model.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator multiply path.
package calc_pkg;

    localparam int OP_W      = 3;   // sign-magnitude operand width
    localparam int RES_W     = 5;   // sign-magnitude product width
    localparam int OP_SIGN   = 2;   // sign bit position in an operand
    localparam int RES_SIGN  = 4;   // sign bit position in a product
    localparam int RES_MAG_W = 4;   // product magnitude width
    localparam int CNT_W     = 3;   // compute-cycle counter width (MUL_LAT up to 7)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mul.sv
// 3-bit sign-magnitude multiplier; zero products always carry a positive sign.
module mul
    import calc_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [RES_W-1:0] product
);

    logic [RES_MAG_W-1:0] mag;
    logic                 sign;

    // Unsigned magnitude product plus sign, with negative zero folded to +0.
    always_comb begin
        mag     = RES_MAG_W'(a[OP_SIGN-1:0]) * RES_MAG_W'(b[OP_SIGN-1:0]);
        sign    = (a[OP_SIGN] ^ b[OP_SIGN]) & (mag != '0);
        product = {sign, mag};
    end

endmodule

// File: rtl/mul_sched.sv
// Two-port arbiter and sequencer sharing one mul instance; holds each product
// on the owning requester's response port until it is consumed.
module mul_sched
    import calc_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_a,
    input  logic [OP_W-1:0]  req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_a,
    input  logic [OP_W-1:0]  req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [RES_W-1:0] rsp0_product,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [RES_W-1:0] rsp1_product,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]  a_q, a_d;
    logic [OP_W-1:0]  b_q, b_d;
    logic [RES_W-1:0] res_q, res_d;
    logic [RES_W-1:0] mul_product;

    logic req_any;
    logic gnt;
    logic rsp_ready_own;

    mul u_mul (
        .a       (a_q),
        .b       (b_q),
        .product (mul_product)
    );

    // Arbitration: a lone valid wins outright, a tie is settled by rr.
    always_comb begin
        req_any       = req0_valid | req1_valid;
        gnt           = (req0_valid && req1_valid) ? rr_q : req1_valid;
        rsp_ready_own = owner_q ? rsp1_ready : rsp0_ready;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, count down in CALC, wait for consumer in RESP.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any)        state_d = CALC;
            CALC:    if (cnt_q == '0)    state_d = RESP;
            RESP:    if (rsp_ready_own)  state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Outputs: ready only for the granted port in IDLE, and never during reset.
    always_comb begin
        req0_ready   = rst_n && (state_q == IDLE) && req_any && !gnt;
        req1_ready   = rst_n && (state_q == IDLE) && req_any &&  gnt;
        rsp0_valid   = (state_q == RESP) && !owner_q;
        rsp1_valid   = (state_q == RESP) &&  owner_q;
        rsp0_product = res_q;
        rsp1_product = res_q;
        busy         = (state_q != IDLE);
    end

    // Datapath next values: operand latch, countdown, result capture, rr flip.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    a_d     = gnt ? req1_a : req0_a;
                    b_d     = gnt ? req1_b : req0_b;
                    owner_d = gnt;
                    cnt_d   = CNT_INIT;
                end
            end
            CALC: begin
                if (cnt_q == '0) res_d = mul_product;
                else             cnt_d = cnt_q - 1'b1;
            end
            RESP: begin
                if (rsp_ready_own) rr_d = ~owner_q;
            end
            default: ;
        endcase
    end

    // Datapath registers; all cleared so a reset discards any transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched: vector table plus hand-written corner sequences.
module tb_mul_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-latency instance
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [4:0] rsp0_product, rsp1_product;
    logic       busy;

    // MUL_LAT=4 instance
    logic       r4_rst_n;
    logic       r4_req0_valid, r4_req1_valid, r4_req0_ready, r4_req1_ready;
    logic [2:0] r4_req0_a, r4_req0_b, r4_req1_a, r4_req1_b;
    logic       r4_rsp0_valid, r4_rsp1_valid, r4_rsp0_ready, r4_rsp1_ready;
    logic [4:0] r4_rsp0_product, r4_rsp1_product;
    logic       r4_busy;

    mul_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_product(rsp0_product),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_product(rsp1_product),
        .busy(busy)
    );

    mul_sched #(.MUL_LAT(4)) dut4 (
        .clk(clk), .rst_n(r4_rst_n),
        .req0_valid(r4_req0_valid), .req0_ready(r4_req0_ready), .req0_a(r4_req0_a), .req0_b(r4_req0_b),
        .req1_valid(r4_req1_valid), .req1_ready(r4_req1_ready), .req1_a(r4_req1_a), .req1_b(r4_req1_b),
        .rsp0_valid(r4_rsp0_valid), .rsp0_ready(r4_rsp0_ready), .rsp0_product(r4_rsp0_product),
        .rsp1_valid(r4_rsp1_valid), .rsp1_ready(r4_rsp1_ready), .rsp1_product(r4_rsp1_product),
        .busy(r4_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         port;
        logic [2:0] a;
        logic [2:0] b;
        logic [4:0] exp;
        int         stall;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sign-magnitude reference: magnitude product, sign cleared on zero.
    function automatic logic [4:0] ref_mul(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] m;
        m = {2'b00, a[1:0]} * {2'b00, b[1:0]};
        return {(m != 4'd0) && (a[2] != b[2]), m};
    endfunction

    function automatic logic req_rdy(input bit p);
        return p ? req1_ready : req0_ready;
    endfunction

    function automatic logic rsp_vld(input bit p);
        return p ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [4:0] rsp_prod(input bit p);
        return p ? rsp1_product : rsp0_product;
    endfunction

    task automatic drive_req(input bit p, input logic v, input logic [2:0] a, input logic [2:0] b);
        if (p) begin req1_valid = v; req1_a = a; req1_b = b; end
        else   begin req0_valid = v; req0_a = a; req0_b = b; end
    endtask

    task automatic set_rsp_ready(input bit p, input logic v);
        if (p) rsp1_ready = v;
        else   rsp0_ready = v;
    endtask

    // One complete transaction on a single port with an optional response stall.
    task automatic do_txn(input bit p, input logic [2:0] a, input logic [2:0] b,
                          input logic [4:0] exp, input int stall, input string tag);
        int waited;
        drive_req(p, 1'b1, a, b);
        #1;
        waited = 0;
        while (!req_rdy(p) && waited < 20) begin
            step();
            waited++;
        end
        if (!req_rdy(p)) begin
            timeout({tag, " req_ready"});
            drive_req(p, 1'b0, 3'b000, 3'b000);
            return;
        end
        step();
        drive_req(p, 1'b0, 3'b000, 3'b000);
        waited = 0;
        while (!rsp_vld(p) && waited < 20) begin
            step();
            waited++;
        end
        if (!rsp_vld(p)) begin
            timeout({tag, " rsp_valid"});
            return;
        end
        check({tag, " latency"}, waited, 1);
        check({tag, " product"}, rsp_prod(p), exp);
        check({tag, " other product"}, rsp_prod(!p), exp);
        check({tag, " other valid"}, rsp_vld(!p), 1'b0);
        check({tag, " busy"}, busy, 1'b1);
        for (int s = 0; s < stall; s++) begin
            step();
            check({tag, " stall valid"}, rsp_vld(p), 1'b1);
            check({tag, " stall product"}, rsp_prod(p), exp);
        end
        set_rsp_ready(p, 1'b1);
        step();
        set_rsp_ready(p, 1'b0);
        #1;
        check({tag, " valid cleared"}, rsp_vld(p), 1'b0);
        check({tag, " idle"}, busy, 1'b0);
    endtask

    initial begin
        int         waited;
        int         seen;
        bit         p;
        logic [2:0] a, b;

        vecs[0] = '{port: 1'b0, a: 3'b011, b: 3'b110, exp: 5'b10110, stall: 0};
        vecs[1] = '{port: 1'b0, a: 3'b100, b: 3'b011, exp: 5'b00000, stall: 1};
        vecs[2] = '{port: 1'b1, a: 3'b101, b: 3'b000, exp: 5'b00000, stall: 2};
        vecs[3] = '{port: 1'b1, a: 3'b111, b: 3'b111, exp: 5'b01001, stall: 0};
        vecs[4] = '{port: 1'b0, a: 3'b010, b: 3'b101, exp: 5'b10010, stall: 3};
        vecs[5] = '{port: 1'b1, a: 3'b011, b: 3'b001, exp: 5'b00011, stall: 1};
        vecs[6] = '{port: 1'b1, a: 3'b110, b: 3'b111, exp: 5'b00110, stall: 0};

        rst_n = 1'b0;
        drive_req(1'b0, 1'b1, 3'b011, 3'b011);
        drive_req(1'b1, 1'b1, 3'b011, 3'b011);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        r4_rst_n = 1'b0;
        r4_req0_valid = 1'b0; r4_req0_a = 3'b000; r4_req0_b = 3'b000;
        r4_req1_valid = 1'b0; r4_req1_a = 3'b000; r4_req1_b = 3'b000;
        r4_rsp0_ready = 1'b0; r4_rsp1_ready = 1'b0;

        // Reset state, with both requesters valid while rst_n is low
        repeat (3) step();
        check("reset req0_ready", req0_ready, 1'b0);
        check("reset req1_ready", req1_ready, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset rsp0_valid", rsp0_valid, 1'b0);
        check("reset rsp1_valid", rsp1_valid, 1'b0);
        check("reset product", rsp0_product, 5'b00000);
        drive_req(1'b0, 1'b0, 3'b000, 3'b000);
        drive_req(1'b1, 1'b0, 3'b000, 3'b000);
        rst_n = 1'b1;
        step();

        // Simultaneous requests held valid: grants alternate 0,1,0,1
        drive_req(1'b0, 1'b1, 3'b111, 3'b111);
        drive_req(1'b1, 1'b1, 3'b010, 3'b001);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            while (!req0_ready && !req1_ready && waited < 10) begin
                step();
                waited++;
            end
            if (!req0_ready && !req1_ready) begin
                timeout("rr grant");
                break;
            end
            check("rr both ready", req0_ready & req1_ready, 1'b0);
            p = req1_ready;
            check("rr grant order", p, g[0]);
            step();
            waited = 0;
            while (!rsp_vld(p) && waited < 10) begin
                step();
                waited++;
            end
            if (!rsp_vld(p)) begin
                timeout("rr rsp");
                break;
            end
            check("rr product", rsp_prod(p), p ? 5'b00010 : 5'b01001);
            step();
        end
        drive_req(1'b0, 1'b0, 3'b000, 3'b000);
        drive_req(1'b1, 1'b0, 3'b000, 3'b000);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (3) step();

        // Table-driven single-port transactions
        for (int i = 0; i < 7; i++)
            do_txn(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, $sformatf("vec%0d", i));

        // Back-pressure on port 1 while port 0 waits
        drive_req(1'b1, 1'b1, 3'b011, 3'b011);
        #1;
        waited = 0;
        while (!req1_ready && waited < 10) begin step(); waited++; end
        if (!req1_ready) timeout("bp req1_ready");
        step();
        drive_req(1'b1, 1'b0, 3'b000, 3'b000);
        step();
        check("bp rsp1_valid", rsp1_valid, 1'b1);
        drive_req(1'b0, 1'b1, 3'b001, 3'b001);
        for (int s = 0; s < 5; s++) begin
            step();
            check("bp req0_ready", req0_ready, 1'b0);
            check("bp busy", busy, 1'b1);
            check("bp rsp1_valid held", rsp1_valid, 1'b1);
            check("bp product held", rsp1_product, 5'b01001);
        end
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;
        #1;
        check("bp rsp1 released", rsp1_valid, 1'b0);
        check("bp req0 granted", req0_ready, 1'b1);
        step();
        drive_req(1'b0, 1'b0, 3'b000, 3'b000);
        step();
        check("bp rsp0_valid", rsp0_valid, 1'b1);
        check("bp rsp0 product", rsp0_product, 5'b00001);
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;

        // Reset in the second CALC cycle with MUL_LAT=4
        r4_rst_n = 1'b1;
        step();
        r4_req0_valid = 1'b1; r4_req0_a = 3'b011; r4_req0_b = 3'b011;
        #1;
        check("r4 req0_ready", r4_req0_ready, 1'b1);
        step();
        r4_req0_valid = 1'b0;
        check("r4 busy in calc", r4_busy, 1'b1);
        step();
        r4_rst_n = 1'b0;
        step();
        check("r4 reset busy", r4_busy, 1'b0);
        check("r4 reset rsp0_valid", r4_rsp0_valid, 1'b0);
        check("r4 reset rsp1_valid", r4_rsp1_valid, 1'b0);
        check("r4 reset product", r4_rsp0_product, 5'b00000);
        check("r4 reset req0_ready", r4_req0_ready, 1'b0);
        r4_rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (r4_rsp0_valid || r4_rsp1_valid) seen++;
        end
        check("r4 discarded txn", seen, 0);

        // MUL_LAT=4 latency on port 1
        r4_req1_valid = 1'b1; r4_req1_a = 3'b110; r4_req1_b = 3'b011;
        #1;
        check("r4 req1_ready", r4_req1_ready, 1'b1);
        step();
        r4_req1_valid = 1'b0;
        waited = 0;
        while (!r4_rsp1_valid && waited < 20) begin step(); waited++; end
        check("r4 latency", waited, 4);
        check("r4 product", r4_rsp1_product, 5'b10110);
        r4_rsp1_ready = 1'b1;
        step();
        r4_rsp1_ready = 1'b0;

        // All 64 operand pairs, alternating ports, random response stalls
        for (int i = 0; i < 64; i++) begin
            a = i[5:3];
            b = i[2:0];
            do_txn(i[0], a, b, ref_mul(a, b), int'($urandom_range(0, 3)), $sformatf("sweep%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
